// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit positions,
// FSM state types and the divisor floor.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_EMPTY    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_TX_OVR      = 3;
    localparam int ST_RX_OVR      = 4;
    localparam int ST_FRAME_ERR   = 5;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Half-bit sampling needs at least two cycles per bit.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO. The caller gates push/pop; pointers carry a wrap bit so
// full and empty are distinguishable when the index bits match.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/uart_mmio.sv
// Full-duplex 8N1 UART on the core's MMIO load/store bus with TX/RX FIFOs,
// runtime divisor, sticky error flags and a registered level interrupt.
//  state    | meaning
//  TX_IDLE  | line high, pops FIFO when non-empty
//  TX_START | start bit (low) for one divisor period
//  TX_DATA  | 8 data bits, LSB first
//  TX_STOP  | stop bit (high); chains straight into the next START if data waits
//  RX_IDLE  | waiting for a falling edge on the synchronised line
//  RX_START | half-bit re-check to reject glitches
//  RX_DATA  | 8 samples, one per divisor period from the start midpoint
//  RX_STOP  | stop sample: push byte or flag a framing error
module uart_mmio
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV  = 868,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int ADDR_SEL_BIT = 31
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        wr_valid,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_valid,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic        uart_txd_in,
    output logic        uart_rxd_out,
    output logic        irq
);
    logic        wr_hit, rd_hit, status_wr;
    logic [1:0]  wr_reg, rd_reg;
    logic [15:0] baud_q;
    logic        irq_en_q, tx_ovr_q, rx_ovr_q, frame_err_q, irq_q;
    logic [31:0] rd_data_q, rd_data_d;
    logic [5:0]  status;

    logic        tx_push_req, tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_dout;
    logic        rx_push_req, rx_push, rx_pop, rx_full, rx_empty, rx_ovr_set, frame_err_set;
    logic [7:0]  rx_dout;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;

    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;

    logic        unused_bits;
    assign unused_bits = ^{wr_addr, rd_addr, wr_data};

    assign wr_hit    = wr_valid && wr_addr[ADDR_SEL_BIT];
    assign rd_hit    = rd_valid && rd_addr[ADDR_SEL_BIT];
    assign wr_reg    = wr_addr[3:2];
    assign rd_reg    = rd_addr[3:2];
    assign status_wr = wr_hit && (wr_reg == REG_STATUS);

    // TX overflow is judged on the pre-cycle full flag, even if the engine pops this cycle.
    assign tx_push_req = wr_hit && (wr_reg == REG_DATA);
    assign tx_push     = tx_push_req && !tx_full;
    assign rx_pop      = rd_hit && (rd_reg == REG_DATA) && !rx_empty;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign rx_ovr_set  = rx_push_req && rx_full && !rx_pop;

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .i_reset(i_reset), .push_i(tx_push), .din_i(wr_data[7:0]), .pop_i(tx_pop),
        .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .i_reset(i_reset), .push_i(rx_push), .din_i(rx_shift_q), .pop_i(rx_pop),
        .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty)
    );

    assign status = {frame_err_q, rx_ovr_q, tx_ovr_q, !rx_empty, tx_full, tx_empty};

    always_comb begin
        rd_data_d = '0;
        if (rd_hit) begin
            case (rd_reg)
                REG_DATA:   rd_data_d = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_dout};
                REG_STATUS: rd_data_d = {26'd0, status};
                REG_BAUD:   rd_data_d = {16'd0, baud_q};
                default:    rd_data_d = {31'd0, irq_en_q};
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as its W1C wins so no event is lost.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            baud_q      <= 16'(DEFAULT_DIV);
            irq_en_q    <= 1'b0;
            tx_ovr_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rd_data_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_hit && wr_reg == REG_BAUD) baud_q   <= clamp_div(wr_data[15:0]);
            if (wr_hit && wr_reg == REG_CTRL) irq_en_q <= wr_data[0];
            if (tx_push_req && tx_full)                   tx_ovr_q <= 1'b1;
            else if (status_wr && wr_data[ST_TX_OVR])     tx_ovr_q <= 1'b0;
            if (rx_ovr_set)                               rx_ovr_q <= 1'b1;
            else if (status_wr && wr_data[ST_RX_OVR])     rx_ovr_q <= 1'b0;
            if (frame_err_set)                            frame_err_q <= 1'b1;
            else if (status_wr && wr_data[ST_FRAME_ERR])  frame_err_q <= 1'b0;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_en_q && (!rx_empty || rx_ovr_q || frame_err_q);
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = irq_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                    tx_div_d   = baud_q;
                    tx_cnt_d   = baud_q - 16'd1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_cnt_d = tx_cnt_q - 16'd1;
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = tx_div_q - 16'd1;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_cnt_d = tx_cnt_q - 16'd1;
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = tx_div_q - 16'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_cnt_d = tx_cnt_q - 16'd1;
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_IDLE;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_dout;
                        tx_div_d   = baud_q;
                        tx_cnt_d   = baud_q - 16'd1;
                        tx_state_d = TX_START;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_div_d      = rx_div_q;
        rx_shift_d    = rx_shift_q;
        rx_bit_d      = rx_bit_q;
        rx_push_req   = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_div_d   = baud_q;
                    rx_cnt_d   = (baud_q >> 1) - 16'd1;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                rx_cnt_d = rx_cnt_q - 16'd1;
                if (rx_cnt_q == 16'd0) begin
                    rx_cnt_d   = rx_div_q - 16'd1;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_cnt_q - 16'd1;
                if (rx_cnt_q == 16'd0) begin
                    rx_cnt_d   = rx_div_q - 16'd1;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            default: begin
                rx_cnt_d = rx_cnt_q - 16'd1;
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d    = RX_IDLE;
                    rx_push_req   = rx_s2_q;
                    frame_err_set = !rx_s2_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'(DEFAULT_DIV);
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= 16'(DEFAULT_DIV);
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_s1_q    <= uart_txd_in;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end

    assign uart_rxd_out = (tx_state_q == TX_START) ? 1'b0 :
                          (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;

endmodule
